rr_arbiter_4: RTL and testbench
===============================

# rr_arbiter_4

Four-requester round-robin arbiter that shares one downstream resource, such as a bus slot or an encoder-fed datapath port, between four clients. It produces a one-hot grant and a 2-bit binary grant index. The index uses the standard 4-to-2 encoding: grant 0001→00, 0010→01, 0100→10, 1000→11. It sits between the requesting clients and the shared resource, and guarantees that at most one grant bit is ever high.

## Interface
Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one owner may keep the grant while another requester waits; 0 means unlimited.
- CNT_W, default 4: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, [3:0]: request from each client, level-sensitive.
- grant, output, [3:0]: registered one-hot grant, or 0000 when idle.
- grant_idx, output, [1:0]: binary index of the current owner; 00 when idle.
- grant_valid, output, 1: high when any grant bit is high.
- lock, input, 1: present only with RR_ARB_LOCK_EN; the owner's lock request.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - BUSY: owner = grant_idx.
- Priority pointer ptr[1:0]:
  - Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4, with natural 2-bit wrap.
  - After granting client i, ptr becomes i+1 mod 4.
- IDLE → BUSY:
  - Occurs on any clock edge where req != 0.
  - The winner is the first set bit in the search order.
- BUSY, req[owner]=1, hold counter < MAX_HOLD (or MAX_HOLD=0): the grant is held and the counter increments.
- BUSY, req[owner]=1, hold counter reaches MAX_HOLD:
  - If another requester is active: the grant is re-arbitrated, excluding the owner; the new owner takes the grant on the same edge and the counter resets to 0.
  - If no other requester is active: the owner keeps the grant and the counter resets to 0.
- BUSY, req[owner]=0:
  - If other requests are pending: re-arbitrate on the same edge, so handover has zero bubble.
  - If nothing is pending: go to IDLE with grant=0000.
- The hold counter counts only while in BUSY, saturating at 2^CNT_W-1, and resets on every ownership change.
- Invariants:
  - grant is always 0000 or one-hot, never multi-hot.
  - grant_idx always equals the encoding of grant.
  - grant_valid = |grant.
- Requests from non-owners have no effect until arbitration, and a request can be dropped without penalty.

## Timing
- Reset: grant=0000, grant_idx=00, grant_valid=0, ptr=00, counter=0, state IDLE.
  - Reset applies immediately on rst_n falling, with no clock needed.
  - Reset mid-grant drops the grant immediately and discards ptr history.
- Latency: req sampled on edge N produces grant visible after edge N. This is 1 cycle from req assertion to grant, because all outputs are registered.
- Release latency: the owner deasserts req before edge N; after edge N its grant is 0 and the next owner, if any, is granted.
- Simultaneous events: multiple requests arriving in the same cycle are resolved purely by ptr. Deassertion by the owner coinciding with hold expiry is treated as release.
- Fairness bound: with MAX_HOLD=M>0, a continuously requesting client waits at most 3·(M+1) cycles.

## Configuration
- RR_ARB_LOCK_EN defined:
  - Adds the lock input.
  - While in BUSY with lock=1 and req[owner]=1, the hold counter is frozen and expiry is suppressed; the owner keeps the grant indefinitely.
  - lock is ignored in IDLE and for non-owners.
  - Deasserting req[owner] still releases the grant, whatever the state of lock.
- RR_ARB_LOCK_EN undefined: no lock port, and hold expiry always applies.

## Test plan
- Reset/idle: assert rst_n=0 mid-grant, then release, with req=0000 → grant=0000, idx=00, valid=0 immediately; after reset, req=0100 → grant=0100, idx=10 one cycle later.
- Rotation: with ptr=00, req=1111 held, MAX_HOLD=0, each owner drops req for one cycle in turn → grants 0001, 0010, 0100, 1000, then 0001 again, with zero-bubble handover and idx sequence 00, 01, 10, 11.
- Hold timeout: MAX_HOLD=3, req=0011 constant → client 0 holds the grant for 4 cycles, then client 1 is granted for 4 cycles, then client 0 again.
- Sole requester: MAX_HOLD=3, req=1000 for 20 cycles → grant stays 1000 throughout with no drop at expiry.
- Simultaneous release and request: the owner at idx 01 drops req in the same cycle that req[3] and req[0] rise, with ptr=10 → next grant is 1000.
- Lock (RR_ARB_LOCK_EN defined): MAX_HOLD=2, owner 0 with lock=1 and req=0011 for 10 cycles → grant stays 0001 throughout; lock=0 → client 1 is granted after 3 further cycles.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 -- four-requester round-robin arbiter with hold timeout.
//
// Grants one of four level-sensitive requesters at a time. Ownership is kept
// while the owner requests. It moves on a release, or when the hold limit
// expires while another client waits. All outputs come straight from flops.
//
// Parameters:
//   MAX_HOLD  max consecutive cycles an owner keeps the grant while others
//             wait (0 = unlimited)
//   CNT_W     hold counter width; 2**CNT_W must exceed MAX_HOLD
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req[3:0]     per-client request, level-sensitive
//   lock         (only with RR_ARB_LOCK_EN) owner asks to keep the grant
//   grant[3:0]   one-hot grant, 0000 when idle
//   grant_idx    binary index of the owner, 00 when idle
//   grant_valid  any grant bit high
//
// Optional feature macro: RR_ARB_LOCK_EN (adds the lock input).

module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
`ifdef RR_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HoldLim = CNT_W'(MAX_HOLD);

    state_e           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] owner_oh;
    logic [3:0] others;
    logic       owner_req;
    logic       expired;
    logic       lock_hold;

    // First set bit of vec, searching start, start+1, ... with 2-bit wrap.
    function automatic logic [1:0] rr_pick(input logic [3:0] vec, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign owner_oh  = 4'b0001 << owner_q;
    // Owner bit masked: used for release handover and for expiry re-arbitration.
    assign others    = req & ~owner_oh;
    assign owner_req = req[owner_q];
    assign expired   = (MAX_HOLD != 0) && (cnt_q >= HoldLim);

`ifdef RR_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 2'b00;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    owner_d = rr_pick(req, ptr_q);
                    ptr_d   = owner_d + 2'd1;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!owner_req) begin
                    // Release wins over expiry and lock; hand over with no bubble.
                    cnt_d = '0;
                    if (|others) begin
                        owner_d = rr_pick(others, ptr_q);
                        ptr_d   = owner_d + 2'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (lock_hold) begin
                    // Locked owner: counter frozen, no expiry.
                    cnt_d = cnt_q;
                end else if (expired) begin
                    // Sole requester simply restarts its hold window.
                    cnt_d = '0;
                    if (|others) begin
                        owner_d = rr_pick(others, ptr_q);
                        ptr_d   = owner_d + 2'd1;
                    end
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode registered state only, so they are glitch-free.
    always_comb begin
        grant       = 4'b0000;
        grant_idx   = 2'b00;
        grant_valid = 1'b0;
        if (state_q == StBusy) begin
            grant       = owner_oh;
            grant_idx   = owner_q;
            grant_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4 -- self-checking bench for rr_arbiter_4.
// Three instances share req: MAX_HOLD = 0, 3 and 2. Each scenario resets them
// all and checks the instance whose hold limit suits it.

module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
`ifdef RR_ARB_LOCK_EN
    logic       lock;
`endif

    logic [3:0] g0, g3, g2;
    logic [1:0] i0, i3, i2;
    logic       v0, v3, v2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] sb[$];

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(0), .CNT_W(4)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
`ifdef RR_ARB_LOCK_EN
        .lock        (1'b0),
`endif
        .grant       (g0),
        .grant_idx   (i0),
        .grant_valid (v0)
    );

    rr_arbiter_4 #(.MAX_HOLD(3), .CNT_W(4)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
`ifdef RR_ARB_LOCK_EN
        .lock        (1'b0),
`endif
        .grant       (g3),
        .grant_idx   (i3),
        .grant_valid (v3)
    );

    rr_arbiter_4 #(.MAX_HOLD(2), .CNT_W(4)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
`ifdef RR_ARB_LOCK_EN
        .lock        (lock),
`endif
        .grant       (g2),
        .grant_idx   (i2),
        .grant_valid (v2)
    );

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: return 2'b01;
            4'b0100: return 2'b10;
            4'b1000: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
`ifdef RR_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        do_reset();
        n_tests++;
        if (g0 !== 4'b0000 || i0 !== 2'b00 || v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: grant=%b idx=%b valid=%b, expected 0000/00/0", g0, i0, v0);
        end
        @(negedge clk); req = 4'b0010; sb.push_back(4'b0010);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_tests++;
        if (g0 !== e || i0 !== enc(e) || v0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pregrant: grant=%b idx=%b valid=%b, expected %b/%b/1",
                     g0, i0, v0, e, enc(e));
        end
        // Assert reset mid-cycle, away from any clock edge.
        #2; rst_n = 1'b0; req = 4'b0000; #1;
        n_tests++;
        if (g0 !== 4'b0000 || i0 !== 2'b00 || v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: grant=%b idx=%b valid=%b, expected 0000/00/0", g0, i0, v0);
        end
        #1; rst_n = 1'b1;
        @(negedge clk); req = 4'b0100; sb.push_back(4'b0100);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_tests++;
        if (g0 !== e || i0 !== 2'b10 || v0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: grant=%b idx=%b valid=%b, expected %b/10/1",
                     g0, i0, v0, e);
        end
        // ptr was 3 here; after reset it must start again from 0.
        do_reset();
        @(negedge clk); req = 4'b1111; sb.push_back(4'b0001);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_tests++;
        if (g0 !== e || i0 !== enc(e) || v0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ptr: grant=%b idx=%b, expected %b/%b", g0, i0, e, enc(e));
        end
    endtask

    task automatic test_rotation();
        logic [3:0] stim[9];
        logic [3:0] expv[9];
        logic [3:0] e;
        stim = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                 4'b1111, 4'b1011, 4'b1111, 4'b0111};
        expv = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                 4'b0100, 4'b1000, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); req = stim[i]; sb.push_back(expv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (g0 !== e || i0 !== enc(e) || v0 !== (e != 4'b0000)) begin
                n_fail++;
                $display("FAIL rotation step %0d: grant=%b idx=%b valid=%b, expected %b/%b/%b",
                         i, g0, i0, v0, e, enc(e), (e != 4'b0000));
            end
        end
    endtask

    task automatic test_hold_timeout();
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); req = 4'b0011;
            sb.push_back((i >= 4 && i < 8) ? 4'b0010 : 4'b0001);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (g3 !== e || i3 !== enc(e) || v3 !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_timeout cycle %0d: grant=%b idx=%b valid=%b, expected %b/%b/1",
                         i, g3, i3, v3, e, enc(e));
            end
        end
    endtask

    task automatic test_sole_requester();
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); req = 4'b1000; sb.push_back(4'b1000);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (g3 !== e || i3 !== 2'b11 || v3 !== 1'b1) begin
                n_fail++;
                $display("FAIL sole_requester cycle %0d: grant=%b idx=%b valid=%b, expected %b/11/1",
                         i, g3, i3, v3, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] stim[5];
        logic [3:0] expv[5];
        logic [3:0] e;
        // Client 1 owns (ptr=2), then drops as 3 and 0 rise; finally all idle.
        stim = '{4'b0010, 4'b0010, 4'b1001, 4'b1001, 4'b0000};
        expv = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); req = stim[i]; sb.push_back(expv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (g0 !== e || i0 !== enc(e) || v0 !== (e != 4'b0000)) begin
                n_fail++;
                $display("FAIL simultaneous step %0d: grant=%b idx=%b valid=%b, expected %b/%b/%b",
                         i, g0, i0, v0, e, enc(e), (e != 4'b0000));
            end
        end
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk); req = 4'b0011; lock = (i < 10);
            sb.push_back((i == 12) ? 4'b0010 : 4'b0001);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (g2 !== e || i2 !== enc(e) || v2 !== 1'b1) begin
                n_fail++;
                $display("FAIL lock cycle %0d: grant=%b idx=%b valid=%b, expected %b/%b/1",
                         i, g2, i2, v2, e, enc(e));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_hold_timeout();
        test_sole_requester();
        test_simultaneous();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
